// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO family: default thresholds and
// an elaboration-time ceiling log2.
package fifo_pkg;

  localparam int DEF_ALMOST_EMPTY_TH    = 4;
  localparam int DEF_ALMOST_FULL_MARGIN = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sdpram_1clk.sv
// Simple dual-port RAM, one clock, one write port and one registered read
// port; written so synthesis maps it onto block RAM.
module sdpram_1clk
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // NOTE: the array and its read register carry no reset; a reset term would stop block-RAM inference.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: registered-read RAM, then a
// RAM-output stage (s1) and the presented output register (s2).
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 11,
  parameter int ALMOST_FULL_TH  = (1 << ADDR_WIDTH) - DEF_ALMOST_FULL_MARGIN,
  parameter int ALMOST_EMPTY_TH = DEF_ALMOST_EMPTY_TH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int              DEPTH     = 1 << ADDR_WIDTH;
  localparam int              CW        = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]   DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]   AF_TH     = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0]   AE_TH     = CW'(ALMOST_EMPTY_TH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  s1_valid_q, s1_valid_d, s1_byp_q, s1_byp_d;
  logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;

  logic                  wr_accept, pop, ram_empty, ram_re, ram_we;
  logic                  move12, s1_free, byp_s1, byp_s2;
  logic [DATA_WIDTH-1:0] ram_rd_data, s1_data;

  assign full         = (count_q == DEPTH_CNT);
  assign almost_full  = (count_q >= AF_TH);
  assign almost_empty = (count_q <= AE_TH);
  assign empty        = !s2_valid_q;
  assign count        = count_q;
  assign rd_data      = s2_data_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_accept = wr_en && !full;
  assign pop       = rd_en && s2_valid_q;
  assign ram_we    = wr_accept && !rst;

  // The prefetch stages refill whenever the RAM holds words, so the RAM never
  // holds DEPTH words and equal pointers always mean it is empty.
  assign ram_empty = (wr_ptr_q == rd_ptr_q);
  assign move12    = s1_valid_q && (!s2_valid_q || pop);
  assign s1_free   = !s1_valid_q || move12;
  assign ram_re    = !ram_empty && s1_free;
  assign s1_data   = s1_byp_q ? byp_data_q : ram_rd_data;

  // While a word is presented and the RAM is drained, a new word skips the
  // RAM read so streaming at low occupancy has no bubble; the read pointer
  // still steps over the slot the word was written to.
  assign byp_s2 = wr_accept && pop && !s1_valid_q && ram_empty;
  assign byp_s1 = wr_accept && s2_valid_q && ram_empty && s1_free && !byp_s2;

  sdpram_1clk #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (ram_we),
    .wr_addr(wr_ptr_q),
    .wr_data(wr_data),
    .rd_en  (ram_re),
    .rd_addr(rd_ptr_q),
    .rd_data(ram_rd_data)
  );

  // NOTE: every always_comb output is defaulted first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    s1_valid_d  = s1_valid_q;
    s1_byp_d    = s1_byp_q;
    byp_data_d  = byp_data_q;
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    overflow_d  = wr_en && full;
    underflow_d = rd_en && !s2_valid_q;

    if (wr_accept) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (ram_re || byp_s1 || byp_s2) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);

    if (wr_accept && !pop)      count_d = count_q + CW'(1);
    else if (!wr_accept && pop) count_d = count_q - CW'(1);

    if (move12) s1_valid_d = 1'b0;
    if (ram_re) begin
      s1_valid_d = 1'b1;
      s1_byp_d   = 1'b0;
    end else if (byp_s1) begin
      s1_valid_d = 1'b1;
      s1_byp_d   = 1'b1;
      byp_data_d = wr_data;
    end

    if (pop) s2_valid_d = 1'b0;
    if (move12) begin
      s2_valid_d = 1'b1;
      s2_data_d  = s1_data;
    end else if (byp_s2) begin
      s2_valid_d = 1'b1;
      s2_data_d  = wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_byp_q    <= 1'b0;
      byp_data_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      s1_valid_q  <= s1_valid_d;
      s1_byp_q    <= s1_byp_d;
      byp_data_q  <= byp_data_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench for sync_fifo_fwft at DEPTH=16; inputs change and outputs
// are sampled on the falling edge.
module tb_sync_fifo_fwft;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          full, almost_full, empty, almost_empty, overflow, underflow;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;

  int n_pass   = 0;
  int n_checks = 0;

  sync_fifo_fwft #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .ALMOST_FULL_TH (12),
    .ALMOST_EMPTY_TH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .full        (full),
    .almost_full (almost_full),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst   = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h5A;
    tick();
    n_checks++;
    if ({empty, almost_empty, full, almost_full, overflow, underflow} !== 6'b110000)
      $display("FAIL reset_flags: got %b want 110000",
               {empty, almost_empty, full, almost_full, overflow, underflow});
    else n_pass++;
    n_checks++;
    if (count !== 5'd0) $display("FAIL reset_count: got %0d want 0", count);
    else n_pass++;
    n_checks++;
    if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h want 00", rd_data);
    else n_pass++;
    wr_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({empty, count} !== {1'b1, 5'd0})
      $display("FAIL reset_release: got empty=%b count=%0d want empty=1 count=0", empty, count);
    else n_pass++;
  endtask

  task automatic test_first_word;
    do_reset();
    wr_data = 8'hA5;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    n_checks++;
    if ({empty, count} !== {1'b1, 5'd1})
      $display("FAIL first_t0: got empty=%b count=%0d want empty=1 count=1", empty, count);
    else n_pass++;
    tick();
    n_checks++;
    if (empty !== 1'b1) $display("FAIL first_t1_empty: got %b want 1", empty);
    else n_pass++;
    tick();
    n_checks++;
    if ({empty, rd_data} !== {1'b0, 8'hA5})
      $display("FAIL first_t2: got empty=%b data=%h want empty=0 data=a5", empty, rd_data);
    else n_pass++;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if ({empty, count} !== {1'b1, 5'd0})
      $display("FAIL first_pop: got empty=%b count=%0d want empty=1 count=0", empty, count);
    else n_pass++;
  endtask

  task automatic test_fill_full;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(i);
      wr_en   = 1'b1;
      tick();
      n_checks++;
      if (count !== 5'(i + 1)) $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1);
      else n_pass++;
      n_checks++;
      if ({almost_full, full, almost_empty} !== {(i + 1 >= 12), (i + 1 == 16), (i + 1 <= 4)})
        $display("FAIL fill_flags[%0d]: got af=%b f=%b ae=%b", i, almost_full, full, almost_empty);
      else n_pass++;
    end
    wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    n_checks++;
    if ({overflow, count} !== {1'b1, 5'd16})
      $display("FAIL overflow_pulse: got ovf=%b count=%0d want ovf=1 count=16", overflow, count);
    else n_pass++;
    tick();
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL overflow_one_cycle: got %b want 0", overflow);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if ({empty, rd_data} !== {1'b0, 8'(i)})
        $display("FAIL drain[%0d]: got empty=%b data=%h want empty=0 data=%h", i, empty, rd_data, 8'(i));
      else n_pass++;
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    n_checks++;
    if ({empty, count} !== {1'b1, 5'd0})
      $display("FAIL drain_end: got empty=%b count=%0d want empty=1 count=0", empty, count);
    else n_pass++;
  endtask

  task automatic test_streaming;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wr_data = 8'(i);
      wr_en   = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    tick();
    for (int c = 0; c < 40; c++) begin
      n_checks++;
      if ({empty, rd_data, count} !== {1'b0, 8'(c), 5'd8})
        $display("FAIL stream[%0d]: got empty=%b data=%h count=%0d want 0 %h 8", c, empty, rd_data, count, 8'(c));
      else n_pass++;
      wr_data = 8'(c + 8);
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if ({empty, rd_data} !== {1'b0, 8'(40 + k)})
        $display("FAIL stream_tail[%0d]: got empty=%b data=%h want 0 %h", k, empty, rd_data, 8'(40 + k));
      else n_pass++;
      tick();
    end
    rd_en = 1'b0;
    n_checks++;
    if ({empty, count} !== {1'b1, 5'd0})
      $display("FAIL stream_end: got empty=%b count=%0d want 1 0", empty, count);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    do_reset();
    wr_data = 8'h50;
    wr_en   = 1'b1;
    tick();
    wr_data = 8'h51;
    tick();
    wr_en = 1'b0;
    tick();
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if ({empty, rd_data, count} !== {1'b0, 8'(8'h50 + c), 5'd2})
        $display("FAIL b2b[%0d]: got empty=%b data=%h count=%0d want 0 %h 2", c, empty, rd_data, count, 8'(8'h50 + c));
      else n_pass++;
      wr_data = 8'(8'h52 + c);
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({empty, rd_data} !== {1'b0, 8'(8'h56 + k)})
        $display("FAIL b2b_tail[%0d]: got empty=%b data=%h want 0 %h", k, empty, rd_data, 8'(8'h56 + k));
      else n_pass++;
      tick();
    end
    rd_en = 1'b0;
    n_checks++;
    if (empty !== 1'b1) $display("FAIL b2b_end: got empty=%b want 1", empty);
    else n_pass++;
  endtask

  task automatic test_underflow;
    do_reset();
    wr_data = 8'h77;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
    tick();
    rd_en = 1'b1;
    tick();
    n_checks++;
    if ({empty, underflow} !== 2'b10)
      $display("FAIL uf_pop: got empty=%b uf=%b want 1 0", empty, underflow);
    else n_pass++;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if ({underflow, count, rd_data, empty} !== {1'b1, 5'd0, 8'h77, 1'b1})
      $display("FAIL uf_pulse: got uf=%b count=%0d data=%h empty=%b want 1 0 77 1", underflow, count, rd_data, empty);
    else n_pass++;
    tick();
    n_checks++;
    if ({underflow, rd_data} !== {1'b0, 8'h77})
      $display("FAIL uf_one_cycle: got uf=%b data=%h want 0 77", underflow, rd_data);
    else n_pass++;
  endtask

  task automatic test_simul_count1;
    do_reset();
    wr_data = 8'h11;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({rd_data, count} !== {8'h11, 5'd1})
      $display("FAIL c1_setup: got data=%h count=%0d want 11 1", rd_data, count);
    else n_pass++;
    wr_data = 8'h22;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_checks++;
    if (count !== 5'd1) $display("FAIL c1_count: got %0d want 1", count);
    else n_pass++;
    if (empty) tick();
    n_checks++;
    if ({empty, rd_data, count} !== {1'b0, 8'h22, 5'd1})
      $display("FAIL c1_next: got empty=%b data=%h count=%0d want 0 22 1", empty, rd_data, count);
    else n_pass++;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if ({empty, count} !== {1'b1, 5'd0})
      $display("FAIL c1_drain: got empty=%b count=%0d want 1 0", empty, count);
    else n_pass++;
  endtask

  task automatic test_simul_full;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(i);
      wr_en   = 1'b1;
      tick();
    end
    wr_data = 8'hEE;
    rd_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    n_checks++;
    if ({overflow, count, full, rd_data} !== {1'b1, 5'd15, 1'b0, 8'h01})
      $display("FAIL full_wr_rd: got ovf=%b count=%0d full=%b data=%h want 1 15 0 01", overflow, count, full, rd_data);
    else n_pass++;
    for (int i = 1; i < 16; i++) begin
      n_checks++;
      if ({empty, rd_data} !== {1'b0, 8'(i)})
        $display("FAIL full_drain[%0d]: got empty=%b data=%h want 0 %h", i, empty, rd_data, 8'(i));
      else n_pass++;
      tick();
    end
    rd_en = 1'b0;
    n_checks++;
    if ({empty, count} !== {1'b1, 5'd0})
      $display("FAIL full_drain_end: got empty=%b count=%0d want 1 0", empty, count);
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      wr_data = 8'(8'h90 + i);
      wr_en   = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    tick();
    n_checks++;
    if ({count, rd_data} !== {5'd9, 8'h90})
      $display("FAIL mid_setup: got count=%0d data=%h want 9 90", count, rd_data);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({count, empty, almost_empty, full, almost_full, rd_data} !== {5'd0, 4'b1100, 8'h00})
      $display("FAIL mid_async: got count=%0d e=%b ae=%b f=%b af=%b data=%h", count, empty, almost_empty, full, almost_full, rd_data);
    else n_pass++;
    @(negedge clk);
    tick();
    #3 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({empty, count} !== {1'b1, 5'd0})
      $display("FAIL mid_release: got empty=%b count=%0d want 1 0", empty, count);
    else n_pass++;
    wr_data = 8'h3C;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({empty, rd_data, count} !== {1'b0, 8'h3C, 5'd1})
      $display("FAIL mid_readback: got empty=%b data=%h count=%0d want 0 3c 1", empty, rd_data, count);
    else n_pass++;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if ({empty, count} !== {1'b1, 5'd0})
      $display("FAIL mid_drain: got empty=%b count=%0d want 1 0", empty, count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_fill_full();
    test_streaming();
    test_back_to_back();
    test_underflow();
    test_simul_count1();
    test_simul_full();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
